// File: rtl/inst_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_sequencer_pkg : core instruction-word layout and sequencer state set
// Rev 1.0
// ----------------------------------------------------------------------------
package inst_sequencer_pkg;

  localparam int INST_W     = 34;
  localparam int ADDR_W     = 11;
  localparam int ADDR_SPACE = 2048;

  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LSB   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LSB   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both memories deselected, write-enables inactive, no FIFO/PE activity.
  localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_W_FETCH = 4'd1,
    S_W_LOAD  = 4'd2,
    S_W_HOLD  = 4'd3,
    S_A_FETCH = 4'd4,
    S_EXEC    = 4'd5,
    S_O_WAIT  = 4'd6,
    S_O_DRAIN = 4'd7,
    S_GAP     = 4'd8,
    S_DONE    = 4'd9
  } state_e;

endpackage
`default_nettype wire

// File: rtl/inst_sequencer_seq_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_counter : loadable saturating down-counter with terminal-count flag
// Rev 1.0
// ----------------------------------------------------------------------------
module seq_counter #(
  parameter int               WIDTH   = 12,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_nxt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next value is exposed so the owner can register outputs aligned with it.
  assign cnt_nxt_o = cnt_d;
  assign tc_o      = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_sequencer : drives the core instruction word through a full len_kij tile
// Rev 1.0
// ----------------------------------------------------------------------------
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int                COL     = 8,
  parameter int                ROW     = 8,
  parameter int                LEN_NIJ = 36,
  parameter int                LEN_KIJ = 9,
  parameter logic [ADDR_W-1:0] W_BASE  = 11'h400,
  parameter logic [ADDR_W-1:0] A_BASE  = 11'h000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              ofifo_valid_i,
  output logic [INST_W-1:0] inst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        kij_idx_o
);

  localparam int T_W = 12;
  localparam int K_W = 4;

  localparam logic [T_W-1:0] W_FETCH_M1 = T_W'(COL - 1);
  localparam logic [T_W-1:0] W_HOLD_M1  = T_W'(COL + 9);
  localparam logic [T_W-1:0] A_FETCH_M1 = T_W'(LEN_NIJ);
  localparam logic [T_W-1:0] EXEC_M1    = T_W'(LEN_NIJ + ROW + COL - 1);
  localparam logic [T_W-1:0] O_DRAIN_M1 = T_W'(LEN_NIJ - 1);
  localparam logic [K_W-1:0] KIJ_LAST   = K_W'(LEN_KIJ - 1);

  if (LEN_KIJ * LEN_NIJ > ADDR_SPACE) begin : g_pmem_overflow
    $error("inst_sequencer: LEN_KIJ*LEN_NIJ exceeds PMEM address space");
  end
  if (int'(W_BASE) + LEN_KIJ * COL > ADDR_SPACE) begin : g_xmem_w_overflow
    $error("inst_sequencer: weight region exceeds XMEM address space");
  end
  if (int'(A_BASE) + LEN_NIJ + 1 > ADDR_SPACE) begin : g_xmem_a_overflow
    $error("inst_sequencer: activation region exceeds XMEM address space");
  end
  if ((LEN_KIJ < 1) || (LEN_KIJ > 16) || (LEN_NIJ < 1) || (COL < 1)) begin : g_dim_range
    $error("inst_sequencer: dimension out of range");
  end
  if (LEN_NIJ + ROW + COL > (1 << T_W)) begin : g_count_range
    $error("inst_sequencer: phase length exceeds counter width");
  end

  // Last t value of each counted phase; phases without a count use 0.
  function automatic logic [T_W-1:0] last_t(input state_e s);
    case (s)
      S_W_FETCH, S_W_LOAD: last_t = W_FETCH_M1;
      S_W_HOLD:            last_t = W_HOLD_M1;
      S_A_FETCH:           last_t = A_FETCH_M1;
      S_EXEC:              last_t = EXEC_M1;
      S_O_DRAIN:           last_t = O_DRAIN_M1;
      default:             last_t = '0;
    endcase
  endfunction

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [INST_W-1:0] inst_q, word_d;
  logic              busy_q, done_q;
  logic [K_W-1:0]    kij_q;

  logic              t_load, t_dec, t_tc;
  logic [T_W-1:0]    t_nxt, t_cur;
  logic              k_load, k_dec, k_tc;
  logic [K_W-1:0]    k_nxt, kij_cur;

  seq_counter #(.WIDTH(T_W), .RST_VAL('0)) u_t_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (t_load),
    .load_val_i (last_t(state_d)),
    .dec_i      (t_dec),
    .cnt_nxt_o  (t_nxt),
    .tc_o       (t_tc)
  );

  seq_counter #(.WIDTH(K_W), .RST_VAL(KIJ_LAST)) u_k_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (k_load),
    .load_val_i (KIJ_LAST),
    .dec_i      (k_dec),
    .cnt_nxt_o  (k_nxt),
    .tc_o       (k_tc)
  );

  // Every state change restarts the phase count; staying put counts down.
  assign t_load = (state_d != state_q);
  assign t_dec  = !t_load;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    k_load  = 1'b0;
    k_dec   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_W_FETCH;
          k_load  = 1'b1;
        end
      end
      S_W_FETCH: begin
        if (t_tc) begin
          state_d = S_GAP;
          ret_d   = S_W_LOAD;
        end
      end
      S_W_LOAD: begin
        if (t_tc) state_d = S_W_HOLD;
      end
      S_W_HOLD: begin
        if (t_tc) begin
          state_d = S_GAP;
          ret_d   = S_A_FETCH;
        end
      end
      S_A_FETCH: begin
        if (t_tc) begin
          state_d = S_GAP;
          ret_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (t_tc) begin
          state_d = S_GAP;
          ret_d   = S_O_WAIT;
        end
      end
      S_O_WAIT: begin
        if (ofifo_valid_i) state_d = S_O_DRAIN;
      end
      S_O_DRAIN: begin
        if (t_tc) begin
          state_d = S_GAP;
          ret_d   = k_tc ? S_DONE : S_W_FETCH;
        end
      end
      S_GAP: begin
        state_d = ret_q;
        k_dec   = (ret_q == S_W_FETCH);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The word is built from next-state values so it lands with the state.
  always_comb begin
    t_cur   = last_t(state_d) - t_nxt;
    kij_cur = KIJ_LAST - k_nxt;
    word_d  = IDLE_WORD;
    case (state_d)
      S_W_FETCH: begin
        word_d[B_CEN_X]    = 1'b0;
        word_d[B_WEN_X]    = 1'b1;
        word_d[B_IFIFO_WR] = 1'b1;
        word_d[B_AX_LSB +: ADDR_W] = W_BASE + ADDR_W'(kij_cur) * ADDR_W'(COL) + ADDR_W'(t_cur);
      end
      S_W_LOAD: begin
        word_d[B_IFIFO_RD] = 1'b1;
        word_d[B_LOAD]     = 1'b1;
      end
      S_W_HOLD: begin
        word_d[B_LOAD] = 1'b1;
      end
      S_A_FETCH: begin
        word_d[B_CEN_X] = 1'b0;
        word_d[B_WEN_X] = 1'b1;
        word_d[B_L0_WR] = 1'b1;
        word_d[B_AX_LSB +: ADDR_W] = A_BASE + ADDR_W'(t_cur);
      end
      S_EXEC: begin
        word_d[B_L0_RD] = 1'b1;
        word_d[B_EXEC]  = 1'b1;
      end
      S_O_DRAIN: begin
        word_d[B_OFIFO_RD] = 1'b1;
        word_d[B_CEN_P]    = 1'b0;
        word_d[B_WEN_P]    = 1'b0;
        word_d[B_AP_LSB +: ADDR_W] = ADDR_W'(kij_cur) * ADDR_W'(LEN_NIJ) + ADDR_W'(t_cur);
      end
      default: ;
    endcase
    word_d[B_ACC] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      inst_q  <= IDLE_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kij_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      inst_q  <= word_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      kij_q   <= kij_cur;
    end
  end

  assign inst_o    = inst_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign kij_idx_o = kij_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_sequencer.sv
`default_nettype none
// tb_inst_sequencer : directed, self-checking bench for inst_sequencer.
module tb_inst_sequencer;

  localparam logic [33:0] IDLE = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;

  int n_checks = 0;
  int n_errors = 0;

  inst_sequencer dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .ofifo_valid_i (ofifo_valid),
    .inst_o        (inst),
    .busy_o        (busy),
    .done_o        (done),
    .kij_idx_o     (kij_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] wf_word(input int a);
    return 34'h1_8004_0020 | (34'(a) << 7);
  endfunction

  function automatic logic [33:0] drain_word(input int a);
    return 34'h0_000C_0040 | (34'(a) << 20);
  endfunction

  // Phase/word tally sampled on the falling edge.
  int wr_cnt [0:2047];
  int n_busy, n_done, n_wf, n_wl, n_wh, n_af, n_ex, n_dr, n_bad;

  always @(negedge clk) begin
    if (busy) n_busy++;
    if (done) n_done++;
    if (inst[33]) n_bad++;
    if (inst[5]) n_wf++;
    if (inst == (IDLE | 34'h11)) n_wl++;
    if (inst == (IDLE | 34'h01)) n_wh++;
    if (inst[2]) n_af++;
    if (inst == (IDLE | 34'h0A)) n_ex++;
    if (inst[6]) begin
      n_dr++;
      wr_cnt[int'(inst[30:20])]++;
      if ((inst[32:31] != 2'b00) || (inst[19:18] != 2'b11)) n_bad++;
    end
  end

  initial begin
    int not_idle;
    int bad_addr;

    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    tick;
    tick;
    check("rst_inst", inst, IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_kij", kij_idx, 0);
    reset = 1'b0;
    tick;

    // Tile 1: weight-fetch addressing, then abort with reset during EXEC.
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wf_word%0d", i), inst, wf_word(32'h400 + i));
      tick;
    end
    check("wf_gap", inst, IDLE);
    tick;
    check("wl_first", inst, IDLE | 34'h11);
    for (int i = 0; i < 200 && !inst[1]; i++) tick;
    check("exec_reached", inst[1], 1);
    repeat (5) tick;
    reset = 1'b1;
    #1;
    check("abort_inst", inst, IDLE);
    check("abort_busy", busy, 0);
    check("abort_kij", kij_idx, 0);
    tick;
    reset = 1'b0;
    tick;
    check("post_abort_idle", inst, IDLE);

    // Tile 2: full run with start toggling while busy.
    foreach (wr_cnt[i]) wr_cnt[i] = 0;
    n_busy = 0; n_done = 0; n_wf = 0; n_wl = 0; n_wh = 0;
    n_af = 0; n_ex = 0; n_dr = 0; n_bad = 0;
    start = 1'b1;
    tick;
    start = 1'b0;

    for (int i = 0; i < 400 && !inst[1]; i++) begin start = ~start; tick; end
    check("ow_exec_seen", inst[1], 1);
    for (int i = 0; i < 100 && inst[1]; i++) begin start = ~start; tick; end
    check("ow_exec_end", inst[1], 0);
    not_idle = 0;
    for (int i = 0; i < 20; i++) begin
      start = ~start;
      if (inst !== IDLE) not_idle++;
      tick;
    end
    check("ow_wait_idle", not_idle, 0);
    start = 1'b0;
    ofifo_valid = 1'b1;
    tick;
    check("ow_first_drain", inst, drain_word(0));

    for (int i = 0; i < 1000 && !(kij_idx == 4'd2 && inst[5]); i++) begin start = ~start; tick; end
    check("k2_wf_first", inst, wf_word(32'h410));
    for (int i = 0; i < 500 && !inst[6]; i++) begin start = ~start; tick; end
    start = 1'b0;
    check("k2_kij", kij_idx, 2);
    check("k2_dr_first", inst, drain_word(72));
    repeat (35) tick;
    check("k2_dr_last", inst, drain_word(107));
    tick;
    check("k2_dr_gap", inst, IDLE);

    start = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) tick;
    check("done_seen", done, 1);
    check("done_kij", kij_idx, 8);
    check("done_busy", busy, 0);
    tick;
    start = 1'b0;
    check("done_pulse", done, 0);
    check("no_retrig_busy", busy, 0);
    check("no_retrig_inst", inst, IDLE);
    repeat (3) tick;
    check("idle_busy", busy, 0);

    bad_addr = 0;
    for (int a = 0; a < 2048; a++) begin
      if (a < 324 && wr_cnt[a] != 1) bad_addr++;
      if (a >= 324 && wr_cnt[a] != 0) bad_addr++;
    end
    check("drain_addr_once", bad_addr, 0);
    check("drain_total", n_dr, 324);
    check("done_count", n_done, 1);
    check("busy_cycles", n_busy, 1504);
    check("wfetch_cycles", n_wf, 72);
    check("wload_cycles", n_wl, 72);
    check("whold_cycles", n_wh, 162);
    check("afetch_cycles", n_af, 333);
    check("exec_cycles", n_ex, 468);
    check("bad_words", n_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
